// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
// Segment codes are active-low {a,b,c,d,e,f,g}.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h01;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h4C;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h20;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h0F;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h0C;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment decoder; codes 10..15 go blank.
module bcd_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode display driver: shadows a BCD word, scans one
// digit per slot with a leading blank interval, leading-zero suppression and DPs.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned BLANK_CYC   = 500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [SEG_W-1:0]      seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an_n
);

    localparam int unsigned PRE_W      = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BLANK_LAST = (BLANK_CYC > 0) ? BLANK_CYC - 1 : 0;

    logic [4*DIGITS-1:0] bcd_sh;
    logic [DIGITS-1:0]   dp_sh;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [3:0]          digit_sel;
    logic                dp_sel;
    logic                lz_sel;
    logic [DIGITS-1:0]   lz_mask;
    logic                zero_above;
    logic [SEG_W-1:0]    dec_seg;

    logic [SEG_W-1:0]    seg_d;
    logic                dp_d;
    logic [DIGITS-1:0]   an_d;

    // Shadow registers load whenever strobed, regardless of scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd_sh <= '0;
            dp_sh  <= '0;
        end else if (load) begin
            bcd_sh <= bcd_in;
            dp_sh  <= dp_in;
        end
    end

    // A digit is a leading zero if it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lz_mask    = '0;
        zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_above = zero_above & (bcd_sh[4*i +: 4] == 4'd0);
            lz_mask[i] = blank_lz & zero_above;
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        dp_sel    = 1'b0;
        lz_sel    = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_sel = bcd_sh[4*i +: 4];
                dp_sel    = dp_sh[i];
                lz_sel    = lz_mask[i];
            end
        end
    end

    bcd_to_seg u_dec (
        .bcd   (digit_sel),
        .seg_c (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pre_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
        end
    end

    // Next state and next pin values; disable forces dark at the sampling edge.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        idx_d   = idx_q;
        seg_d   = SEG_BLANK;
        dp_d    = 1'b1;
        an_d    = '1;

        if (!enable) begin
            state_d = IDLE;
            pre_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
                    pre_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    pre_d = pre_q + PRE_W'(1);
                    if (pre_q == PRE_W'(BLANK_LAST)) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    for (int i = 0; i < int'(DIGITS); i++) begin
                        an_d[i] = (idx_q != IDX_W'(i));
                    end
                    seg_d = lz_sel ? SEG_BLANK : dec_seg;
                    dp_d  = ~dp_sel;
                    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
                        pre_d   = '0;
                        idx_d   = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
                        state_d = (BLANK_CYC == 0) ? SHOW : BLANK;
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    pre_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n <= SEG_BLANK;
            dp_n  <= 1'b1;
            an_n  <= '1;
        end else begin
            seg_n <= seg_d;
            dp_n  <= dp_d;
            an_n  <= an_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboarded bench for seven_seg_scan: a positional model predicts every
// cycle's pins from the time since enable and the loaded word.
module tb_seven_seg_scan;

    localparam int unsigned DIGITS      = 4;
    localparam int unsigned REFRESH_DIV = 8;
    localparam int unsigned BLANK_CYC   = 2;
    localparam int unsigned FRAME       = DIGITS * REFRESH_DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } pins_t;

    pins_t sb_q[$];
    int    errors = 0;
    int    checks = 0;

    logic [15:0] m_bcd;
    logic [3:0]  m_dp;
    int          run_len;

    seven_seg_scan #(
        .DIGITS      (DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYC   (BLANK_CYC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .load     (load),
        .bcd_in   (bcd_in),
        .dp_in    (dp_in),
        .blank_lz (blank_lz),
        .seg_n    (seg_n),
        .dp_n     (dp_n),
        .an_n     (an_n)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'd0: return 7'h01;
            4'd1: return 7'h4F;
            4'd2: return 7'h12;
            4'd3: return 7'h06;
            4'd4: return 7'h4C;
            4'd5: return 7'h24;
            4'd6: return 7'h20;
            4'd7: return 7'h0F;
            4'd8: return 7'h00;
            4'd9: return 7'h0C;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
        end
    endtask

    // Reference: the pins after an edge reflect the scan position one cycle earlier
    // and the word held before this edge's load.
    always @(posedge clk) begin : model
        pins_t e;
        int    pos;
        int    slot;
        int    phase;
        e = '{seg: 7'h7F, dp: 1'b1, an: 4'hF};
        if (!rst_n) begin
            m_bcd   = '0;
            m_dp    = '0;
            run_len = 0;
        end else begin
            if (!enable) begin
                run_len = 0;
            end else begin
                run_len++;
                if (run_len >= 2) begin
                    pos   = (run_len - 2) % int'(FRAME);
                    slot  = pos / int'(REFRESH_DIV);
                    phase = pos % int'(REFRESH_DIV);
                    if (phase >= int'(BLANK_CYC)) begin
                        e.an  = 4'hF & ~(4'b0001 << slot);
                        e.dp  = ~m_dp[slot];
                        if (blank_lz && slot > 0 && (m_bcd >> (4 * slot)) == 16'd0)
                            e.seg = 7'h7F;
                        else
                            e.seg = seg_of(4'(m_bcd >> (4 * slot)));
                    end
                end
            end
            if (load) begin
                m_bcd = bcd_in;
                m_dp  = dp_in;
            end
        end
        sb_q.push_back(e);
    end

    always @(negedge clk) begin : monitor
        pins_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("pins", {seg_n, dp_n, an_n}, {e.seg, e.dp, e.an});
            chk("one_anode", 12'($countones(~an_n) <= 1), 12'd1);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] d);
        bcd_in = b;
        dp_in  = d;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        enable   = 1'b0;
        load     = 1'b0;
        blank_lz = 1'b0;
        bcd_in   = '0;
        dp_in    = '0;
        step(3);
        chk("reset_pins", {seg_n, dp_n, an_n}, {7'h7F, 1'b1, 4'hF});
        rst_n = 1'b1;
        step(3);

        do_load(16'h1234, 4'b0000);
        enable = 1'b1;
        step(70);

        do_load(16'h0050, 4'b0000);
        blank_lz = 1'b1;
        step(34);
        blank_lz = 1'b0;
        step(34);

        do_load(16'h0000, 4'b0000);
        blank_lz = 1'b1;
        step(34);
        blank_lz = 1'b0;

        do_load(16'hFA09, 4'b0100);
        step(34);

        // One dark cycle, restart, then load during digit 0's show phase.
        enable = 1'b0;
        step(1);
        enable = 1'b1;
        step(5);
        do_load(16'h8888, 4'b0001);
        step(40);

        // Asynchronous reset mid-scan goes dark without waiting for an edge.
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        chk("async_reset", {seg_n, dp_n, an_n}, {7'h7F, 1'b1, 4'hF});
        step(2);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        step(5);
        enable = 1'b1;
        step(34);

        repeat (600) begin
            load   = ($urandom_range(0, 7) == 0);
            bcd_in = 16'($urandom);
            dp_in  = 4'($urandom);
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            enable = ($urandom_range(0, 79) != 0);
            step(1);
        end
        load = 1'b0;
        step(2);
        @(negedge clk);
        #1;
        chk("drained", 12'(sb_q.size()), 12'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seven_seg_scan.md
# seven_seg_scan

Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display. It captures a packed BCD word on a load strobe and scans one digit per refresh slot with a one-cold anode select. It also inserts an anti-ghosting blank interval per slot, applies optional leading-zero blanking, and drives per-digit decimal points. It sits between the datapath that produces BCD results and the board's segment/anode pins, and supersedes the single-digit combinational decoder.

## Interface
- DIGITS, 4: number of digits scanned; legal range 1..8.
- REFRESH_DIV, 50000: clock cycles per digit slot; must be ≥ 2.
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV; 0 disables blanking.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  1 = scan; 0 = display dark and scan restarted.
- load  input  1  capture strobe for bcd_in/dp_in.
- bcd_in  input  4*DIGITS  packed BCD; digit i = bcd_in[4i+3:4i], digit 0 = least significant, rightmost.
- dp_in  input  DIGITS  decimal point request per digit, 1 = lit.
- blank_lz  input  1  1 = suppress leading zeros.
- seg_n  output  7  segments {a,b,c,d,e,f,g}, active-low (bit 6 = a, bit 0 = g).
- dp_n  output  1  decimal point, active-low.
- an_n  output  DIGITS  anode select, one-cold, active-low.

## Operation
- Shadow registers: bcd_sh and dp_sh load from bcd_in and dp_in on any rising edge with load=1, independent of enable. The display always reads the shadow registers, never the inputs directly.
- Decode, active-low: 0=7'h01, 1=7'h4F, 2=7'h12, 3=7'h06, 4=7'h4C, 5=7'h24, 6=7'h20, 7=7'h0F, 8=7'h00, 9=7'h0C.
- Codes 10..15 decode to blank (7'h7F), so no segments light.
- Leading-zero blanking: when blank_lz=1, digit i (i>0) shows 7'h7F if it and every digit above it are 0.
- Digit 0 is never blanked by leading-zero blanking.
- dp_n = ~dp_sh[idx] whenever an anode is active and is not affected by leading-zero blanking.
- FSM states:
  - IDLE: all outputs off; prescaler and idx held at 0.
  - BLANK: an_n all 1; seg_n=7'h7F; dp_n=1.
  - SHOW: an_n[idx]=0 and all other anodes 1; seg_n/dp_n show digit idx.
- FSM transitions:
  - IDLE→BLANK when enable=1, or IDLE→SHOW if BLANK_CYC=0.
  - BLANK→SHOW when the prescaler reaches BLANK_CYC-1.
  - SHOW→BLANK (or SHOW→SHOW if BLANK_CYC=0) at prescaler terminal count REFRESH_DIV-1. The prescaler then wraps to 0, and idx advances, wrapping from DIGITS-1 to 0.
  - Any state→IDLE on a cycle with enable=0; this has priority over every other transition.
- Prescaler width is $clog2(REFRESH_DIV); idx width is $clog2(DIGITS), minimum 1.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - Outputs: seg_n=7'h7F, dp_n=1, an_n all 1.
  - Internal: bcd_sh=0, dp_sh=0, idx=0, prescaler=0, state IDLE.
- All outputs are registered; nothing combinational reaches the pins.
- Load latency: bcd_in sampled at edge N appears on seg_n at edge N+1 if the digit is currently in SHOW. Otherwise it appears at that digit's next SHOW entry.
- load held high: the shadow registers update every cycle.
- load coinciding with a slot boundary: the new value is used for the new digit with the same N+1 latency.
- Enable: enable=1 sampled at edge N moves the FSM out of IDLE at that edge, with outputs updated at N+1. The first slot is digit 0 and lasts exactly REFRESH_DIV cycles.
- Full frame = DIGITS*REFRESH_DIV cycles. Each anode is low for exactly REFRESH_DIV-BLANK_CYC consecutive cycles per frame.
- Overlap: no two anodes are ever low in the same cycle, including across slot transitions.
- enable=0 mid-slot: outputs go dark at the next edge and the scan restarts from digit 0 on re-enable.
- rst_n asserted mid-scan: outputs dark immediately; the shadow registers are cleared.

## Structure
- Package seven_seg_pkg holds:
  - the segment constants SEG_0..SEG_9 and SEG_BLANK=7'h7F;
  - the FSM state enum (IDLE, BLANK, SHOW).
- Sub-module bcd_to_seg: a combinational 4-bit→7-bit active-low decoder, with 10..15 decoding to SEG_BLANK. It is instantiated once and fed through a DIGITS:1 mux on idx.
- The leading-zero mask is computed combinationally from bcd_sh in the top level.

## Test plan
Bench parameters for all scenarios: DIGITS=4, REFRESH_DIV=8, BLANK_CYC=2.
- Reset: rst_n=0 mid-scan → seg_n=7'h7F, dp_n=1, an_n=4'b1111 in the same cycle. After release with enable=0, the outputs stay dark.
- Scan order: load bcd_in=16'h1234, enable=1.
  - Per 8-cycle slot: 2 cycles with an_n=4'b1111, then 6 cycles with one anode low.
  - Sequence: an_n=4'b1110/seg_n=7'h4C (4), 1101/7'h06 (3), 1011/7'h12 (2), 0111/7'h4F (1).
  - The sequence repeats every 32 cycles; no cycle has two anodes low.
- Leading zeros: bcd_in=16'h0050, blank_lz=1 → digits 3 and 2 show 7'h7F and digit 1 shows 7'h24. Digit 0 shows 7'h01.
  - With blank_lz=0, digits 3 and 2 show 7'h01.
- bcd_in=16'h0000, blank_lz=1 → only digit 0 shows 7'h01; the others are blank.
- Invalid codes and dp: bcd_in=16'hFA09, dp_in=4'b0100.
  - Digits 3 and 2 show 7'h7F; digit 1 shows 7'h01; digit 0 shows 7'h0C.
  - dp_n=0 only during digit 2's SHOW phase.
- Load and enable interaction:
  - load 16'h8888 during digit 0's SHOW phase → seg_n=7'h00 one cycle later.
  - enable=0 for one cycle → dark next cycle.
  - Re-enable → scan restarts at digit 0 after a 2-cycle BLANK.
